// File: rtl/cnt_seq_pkg.sv
// Shared encodings and defaults for the command-sequenced up/down counter.
package cnt_seq_pkg;

   localparam int unsigned CW_DEFAULT  = 4;
   localparam int unsigned WCW_DEFAULT = 8;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_UP    = 2'b01,
      OP_DOWN  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   function automatic logic is_step_op(op_e op);
      return (op == OP_UP) || (op == OP_DOWN);
   endfunction

endpackage

// File: rtl/updown_cnt4.sv
// Up/down counter datapath: async clear, sync load, enable and direction.
module updown_cnt4
   import cnt_seq_pkg::*;
#(
   parameter int unsigned CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          mr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   input  logic          up_down,
   output logic [CW-1:0] q,
   output logic          wrap
);

   logic [CW-1:0] q_q;
   logic [CW-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         q_d = up_down ? (q_q + CW'(1)) : (q_q - CW'(1));
      end
   end

   always_ff @(posedge clk or posedge mr) begin
      if (mr) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   // High when the coming edge rolls the count over in the selected direction.
   assign wrap = en && !load && (up_down ? (&q_q) : (~|q_q));
   assign q    = q_q;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command sequencer around updown_cnt4: LOAD/CLEAR/UP/DOWN with abort,
// done pulse, registered wrap flag and saturating wrap-event counter.
module cnt_seq_ctrl
   import cnt_seq_pkg::*;
#(
   parameter int unsigned CW  = CW_DEFAULT,
   parameter int unsigned WCW = WCW_DEFAULT
) (
   input  logic           clk,
   input  logic           mr,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [1:0]     cmd_op,
   input  logic [CW-1:0]  cmd_val,
   input  logic           abort,
   output logic [CW-1:0]  q,
   output logic           co,
   output logic           busy,
   output logic           done,
   output logic [WCW-1:0] wrap_cnt
);

   // One extra bit so a zero step count can stand for 2^CW steps.
   localparam logic [CW:0] REM_FULL = {1'b1, {CW{1'b0}}};
   localparam logic [CW:0] REM_ONE  = (CW+1)'(1);

   state_e         state_q, state_d;
   op_e            op_q, op_d;
   logic [CW-1:0]  val_q, val_d;
   logic [CW:0]    rem_q, rem_d;
   logic           co_q, co_d;
   logic [WCW-1:0] wrap_cnt_q, wrap_cnt_d;

   logic           cnt_load;
   logic           cnt_en;
   logic           cnt_up;
   logic [CW-1:0]  cnt_load_val;
   logic           cnt_wrap;
   logic [CW-1:0]  cnt_q;

   updown_cnt4 #(
      .CW (CW)
   ) u_cnt (
      .clk      (clk),
      .mr       (mr),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .up_down  (cnt_up),
      .q        (cnt_q),
      .wrap     (cnt_wrap)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      val_d        = val_q;
      rem_d        = rem_q;
      co_d         = 1'b0;
      wrap_cnt_d   = wrap_cnt_q;
      cnt_load     = 1'b0;
      cnt_en       = 1'b0;
      cnt_up       = (op_q == OP_UP);
      cnt_load_val = (op_q == OP_CLEAR) ? '0 : val_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = op_e'(cmd_op);
               val_d   = cmd_val;
               rem_d   = (cmd_val == '0) ? REM_FULL : {1'b0, cmd_val};
               state_d = is_step_op(op_e'(cmd_op)) ? ST_RUN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               cnt_load = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               cnt_en = 1'b1;
               co_d   = cnt_wrap;
               rem_d  = rem_q - REM_ONE;
               if (rem_q == REM_ONE) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (co_d && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + WCW'(1);
      end
   end

   always_ff @(posedge clk or posedge mr) begin
      if (mr) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_LOAD;
         val_q      <= '0;
         rem_q      <= '0;
         co_q       <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         val_q      <= val_d;
         rem_q      <= rem_d;
         co_q       <= co_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign q         = cnt_q;
   assign co        = co_q;
   assign wrap_cnt  = wrap_cnt_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl with a per-cycle reference model.
module tb_cnt_seq_ctrl;

   localparam int CW   = 4;
   localparam int WCW  = 8;
   localparam int M    = 16;
   localparam int WMAX = 255;

   logic           clk = 1'b0;
   logic           mr = 1'b0;
   logic           cmd_valid = 1'b0;
   logic [1:0]     cmd_op = 2'b00;
   logic [CW-1:0]  cmd_val = '0;
   logic           abort = 1'b0;
   logic           cmd_ready;
   logic [CW-1:0]  q;
   logic           co;
   logic           busy;
   logic           done;
   logic [WCW-1:0] wrap_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cnt_seq_ctrl #(
      .CW  (CW),
      .WCW (WCW)
   ) dut (
      .clk       (clk),
      .mr        (mr),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_val   (cmd_val),
      .abort     (abort),
      .q         (q),
      .co        (co),
      .busy      (busy),
      .done      (done),
      .wrap_cnt  (wrap_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a command becomes a list of future q values, one per edge,
   // followed by one done cycle; abort discards what is left of the list.
   typedef struct {
      int v;
      bit w;
   } step_t;

   step_t plan[$];
   int    m_q  = 0;
   int    m_wc = 0;
   bit    m_co = 1'b0;
   bit    m_done = 1'b0;

   function automatic step_t mk(input int v, input bit w);
      step_t s;
      s.v = v;
      s.w = w;
      return s;
   endfunction

   always @(posedge clk or posedge mr) begin
      step_t s;
      int    n;
      int    v;
      if (mr) begin
         plan.delete();
         m_q    = 0;
         m_wc   = 0;
         m_co   = 1'b0;
         m_done = 1'b0;
      end else begin
         m_co = 1'b0;
         if (m_done) begin
            m_done = 1'b0;
         end else if (plan.size() != 0) begin
            if (abort) begin
               plan.delete();
            end else begin
               s    = plan.pop_front();
               m_q  = s.v;
               m_co = s.w;
               if (s.w && m_wc < WMAX) m_wc++;
               if (plan.size() == 0) m_done = 1'b1;
            end
         end else if (cmd_valid) begin
            n = (cmd_val == 0) ? M : int'(cmd_val);
            case (cmd_op)
               2'b00: plan.push_back(mk(int'(cmd_val), 1'b0));
               2'b11: plan.push_back(mk(0, 1'b0));
               2'b01: for (int i = 1; i <= n; i++) begin
                  v = (m_q + i) % M;
                  plan.push_back(mk(v, v == 0));
               end
               default: for (int i = 1; i <= n; i++) begin
                  v = (((m_q - i) % M) + M) % M;
                  plan.push_back(mk(v, v == M - 1));
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_q",        int'(q),        m_q);
      chk("cyc_co",       int'(co),       int'(m_co));
      chk("cyc_busy",     int'(busy),     int'(plan.size() != 0));
      chk("cyc_done",     int'(done),     int'(m_done));
      chk("cyc_ready",    int'(cmd_ready), int'(plan.size() == 0 && !m_done));
      chk("cyc_wrap_cnt", int'(wrap_cnt), m_wc);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [1:0] op, input logic [CW-1:0] v);
      cmd_op    = op;
      cmd_val   = v;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !cmd_ready; i++) tick();
      chk("send_ready", int'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && !cmd_ready; i++) tick();
      chk("idle_timeout", int'(cmd_ready), 1);
   endtask

   initial begin
      int cocount;

      #1 mr = 1'b1;
      #1;
      chk("rst_q", int'(q), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wrap_cnt", int'(wrap_cnt), 0);
      tick();
      tick();
      mr = 1'b0;

      // LOAD 9
      send(2'b00, 4'd9);
      chk("ld9_busy", int'(busy), 1);
      chk("ld9_q_before", int'(q), 0);
      tick();
      chk("ld9_q", int'(q), 9);
      chk("ld9_done", int'(done), 1);
      chk("ld9_co", int'(co), 0);
      tick();
      chk("ld9_done_end", int'(done), 0);
      chk("ld9_ready", int'(cmd_ready), 1);

      // LOAD 14, UP 3 through the 15->0 wrap
      send(2'b00, 4'd14);
      wait_idle();
      chk("up3_q0", int'(q), 14);
      send(2'b01, 4'd3);
      tick();
      chk("up3_q1", int'(q), 15);
      chk("up3_co1", int'(co), 0);
      tick();
      chk("up3_q2", int'(q), 0);
      chk("up3_co2", int'(co), 1);
      chk("up3_wc", int'(wrap_cnt), 1);
      tick();
      chk("up3_q3", int'(q), 1);
      chk("up3_co3", int'(co), 0);
      chk("up3_done", int'(done), 1);
      tick();
      chk("up3_done_end", int'(done), 0);
      chk("up3_ready", int'(cmd_ready), 1);

      // DOWN 2 with a stray command while running and abort during DONE
      send(2'b10, 4'd2);
      cmd_op    = 2'b00;
      cmd_val   = 4'd3;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("dn2_q1", int'(q), 0);
      tick();
      chk("dn2_q2", int'(q), 15);
      chk("dn2_done", int'(done), 1);
      chk("dn2_wc", int'(wrap_cnt), 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("dn2_q_hold", int'(q), 15);
      chk("dn2_ready", int'(cmd_ready), 1);

      // LOAD 1, DOWN 0 (16 steps)
      send(2'b00, 4'd1);
      wait_idle();
      send(2'b10, 4'd0);
      cocount = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (co) cocount++;
      end
      chk("dn16_q", int'(q), 1);
      chk("dn16_done", int'(done), 1);
      chk("dn16_cocount", cocount, 1);
      chk("dn16_wc", int'(wrap_cnt), 3);
      tick();

      // CLEAR, UP 8 aborted after 3 steps
      send(2'b11, 4'd5);
      wait_idle();
      chk("clr_q", int'(q), 0);
      send(2'b01, 4'd8);
      tick();
      tick();
      tick();
      chk("ab_q3", int'(q), 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_q_hold", int'(q), 3);
      chk("ab_busy", int'(busy), 0);
      chk("ab_done", int'(done), 0);
      chk("ab_ready", int'(cmd_ready), 1);
      tick();
      chk("ab_done2", int'(done), 0);

      // Abort in LOAD skips the pending load
      send(2'b00, 4'd12);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abld_q", int'(q), 3);
      chk("abld_done", int'(done), 0);
      chk("abld_ready", int'(cmd_ready), 1);

      // Reset mid-RUN at q=5
      send(2'b11, 4'd0);
      wait_idle();
      send(2'b01, 4'd10);
      for (int i = 0; i < 5; i++) tick();
      chk("mr_q_before", int'(q), 5);
      chk("mr_busy_before", int'(busy), 1);
      #1 mr = 1'b1;
      #1;
      chk("mr_q", int'(q), 0);
      chk("mr_busy", int'(busy), 0);
      chk("mr_wc", int'(wrap_cnt), 0);
      chk("mr_ready", int'(cmd_ready), 1);
      tick();
      mr = 1'b0;
      send(2'b00, 4'd7);
      chk("mr_accept", int'(busy), 1);
      tick();
      chk("mr_ld7_q", int'(q), 7);
      chk("mr_ld7_done", int'(done), 1);

      // 300 full UP cycles: one wrap each, counter saturates
      wait_idle();
      for (int i = 0; i < 300; i++) begin
         send(2'b01, 4'd0);
         wait_idle();
      end
      chk("sat_wc", int'(wrap_cnt), 255);
      chk("sat_q", int'(q), 7);
      send(2'b11, 4'd9);
      wait_idle();
      chk("sat_clr_q", int'(q), 0);
      chk("sat_clr_wc", int'(wrap_cnt), 255);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

endmodule
